simt_divergence_ctrl: RTL and testbench
=======================================

# simt_divergence_ctrl

Per-warp branch-divergence sequencer for the CGRA core's CTA schedule path. It owns the current (PC, active mask, reconvergence PC) of one warp and issues blocks to the fetch unit. It turns block-completion reports (fall-through, conditional branch, exit) into push, pop and read-top sequences on an attached `simt_stack` instance, which has 1-cycle registered top-read latency. It implements immediate-post-dominator reconvergence and tracks exited threads.

## Interface
- `PC_WIDTH`, 32, PC width
- `THREAD_WIDTH`, 256, threads per warp (mask width)
- `STACK_DEPTH`, 32, entries in attached stack; must match the stack instance
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `launch_valid`/`launch_ready` in/out 1: warp launch handshake
- `launch_pc` in PC_WIDTH, `launch_mask` in THREAD_WIDTH: entry block, initial mask
- `disp_valid`/`disp_ready` out/in 1: block dispatch handshake
- `disp_pc` out PC_WIDTH, `disp_mask` out THREAD_WIDTH: block to run, active mask
- `done_valid`/`done_ready` in/out 1: block completion handshake
- `done_kind` in 2: 0 = fall-through, 1 = branch, 2 = exit, 3 = reserved (treated as exit, sets `err_kind`)
- `done_next_pc` in PC_WIDTH: fall-through target
- `done_taken_mask` in THREAD_WIDTH: branch predicate per thread
- `done_taken_pc`, `done_nt_pc`, `done_reconv_pc` in PC_WIDTH: branch targets, IPDOM
- `warp_done` out 1: 1-cycle pulse when all threads have exited
- `err_overflow`, `err_kind` out 1: sticky error flags, cleared by reset or accepted launch
- `stk_push`, `stk_pop`, `stk_read_top` out 1; `stk_modify_top` out 1, tied 0
- `stk_push_next_pc`, `stk_push_rpc` out PC_WIDTH; `stk_push_mask` out THREAD_WIDTH
- `stk_top_next_pc`, `stk_top_rpc` in PC_WIDTH; `stk_top_mask` in THREAD_WIDTH; `stk_out_valid` in 1

## Operation
- Registers:
  - `cur_pc`, `cur_mask`, `cur_rpc`
  - `exited` (THREAD_WIDTH)
  - `depth` (0..STACK_DEPTH), internal count mirroring stack occupancy
  - `RPC_NONE` = all-ones is the top-level reconvergence sentinel.
- States: IDLE, DISPATCH, WAIT_DONE, PUSH_RECONV, PUSH_NT, POP, LOAD, ERROR.
- IDLE: `launch_ready` = 1. On handshake: `cur_pc` = launch_pc, `cur_mask` = launch_mask, `cur_rpc` = RPC_NONE, `exited` = 0, `depth` = 0, errors cleared; go to DISPATCH.
- DISPATCH: `disp_valid` = 1, `disp_pc` = cur_pc, `disp_mask` = cur_mask. On handshake, go to WAIT_DONE.
- WAIT_DONE: `done_ready` = 1. On handshake:
  - Fall-through: nxt = (done_next_pc, cur_mask).
  - Branch: t = taken & cur_mask, n = cur_mask & ~taken.
    - t == 0: nxt = (nt_pc, cur_mask).
    - n == 0: nxt = (taken_pc, cur_mask).
    - Otherwise divergent:
      - If depth > STACK_DEPTH-2: set `err_overflow`, go to ERROR.
      - Else latch n/nt_pc/reconv_pc. Set cur = (taken_pc, t), cur_rpc = reconv_pc, and stash the old cur_rpc and cur_mask. Go to PUSH_RECONV.
  - Non-divergent nxt: if nxt_pc == cur_rpc and depth > 0, go to POP (nxt discarded). Else cur = nxt, go to DISPATCH.
  - Exit: `exited` |= cur_mask. If depth == 0: pulse `warp_done`, go to IDLE. Else go to POP.
- PUSH_RECONV: push {reconv_pc, old cur_rpc, old cur_mask}; depth+1.
- PUSH_NT: push {nt_pc, reconv_pc, n}; depth+1; go to DISPATCH.
- POP: assert `stk_read_top` and `stk_pop` in the same cycle (read uses the pre-pop pointer); depth−1; go to LOAD.
- LOAD: wait for `stk_out_valid`, then compute m = top_mask & ~exited.
  - m ≠ 0: cur = (top_next_pc, m), cur_rpc = top_rpc, go to DISPATCH.
  - m == 0 and depth > 0: go to POP.
  - m == 0 and depth == 0: pulse `warp_done`, go to IDLE.
- ERROR: all handshakes low. Exit only via reset.
- At most one of push/pop is asserted per cycle. Push and pop are never asserted against a full or empty stack.

## Timing
- Reset:
  - State IDLE.
  - All outputs 0 except `launch_ready` = 1.
  - `cur_rpc` = RPC_NONE; depth 0; exited 0.
- Reset mid-sequence aborts immediately. The stack must be reset by the same `rst`.
- Latency, with the done handshake in cycle N:
  - Uniform: `disp_valid` at N+1.
  - Divergent: pushes at N+1 and N+2, `disp_valid` at N+3.
  - Reconvergence: POP at N+1, LOAD at N+2, `disp_valid` at N+3.
  - Each extra fully-exited entry adds 2 cycles.
- Handshakes complete on valid&ready at the rising edge. Outputs hold stable while valid && !ready.
- `warp_done` and `launch_ready` are never high in the same cycle as any stack command.

## Test plan
- Uniform:
  - Stimulus (THREAD_WIDTH=8): launch pc 0x100, mask 0xFF; done fall-through next 0x140.
  - Required: dispatch (0x100, 0xFF) then (0x140, 0xFF); no stack commands.
- Divergent branch:
  - Stimulus: taken 0x0F, taken_pc 0x200, nt 0x300, reconv 0x400.
  - Required:
    - Pushes {0x400, RPC_NONE, 0xFF} then {0x300, 0x400, 0xF0}.
    - Dispatch (0x200, 0x0F).
    - Fall-through to 0x400 pops and dispatches (0x300, 0xF0).
    - Next 0x400 pops and dispatches (0x400, 0xFF); depth 0.
- Uniform-predicate branch: taken 0x00 and then 0xFF -> dispatch nt_pc then taken_pc, each with mask 0xFF; no pushes.
- Exit in divergence:
  - Stimulus: after the divergent split, the taken path exits.
  - Required: pop, dispatch (0x300, 0xF0). At reconvergence, dispatch (0x400, 0xF0), not 0xFF. A final exit pulses `warp_done` once.
- Overflow: STACK_DEPTH=4, three nested divergent branches -> third sets `err_overflow`, state ERROR, no push issued.
- Async reset during LOAD -> all outputs 0 and `launch_ready` 1 within the reset cycle. A new launch works normally afterwards.

Source files
------------

// File: rtl/simt_divergence_ctrl.sv
// Purpose: per-warp SIMT divergence sequencer; owns (pc, mask, rpc) of one warp and drives an external simt_stack.
// Latency: uniform completion -> dispatch in 1 cycle; divergent split 3 cycles; reconvergence 3 cycles (+2 per fully-exited entry).
// Backpressure: valid/ready on launch, dispatch and done; dispatch outputs hold while disp_valid && !disp_ready.
module simt_divergence_ctrl #(
    parameter int PC_WIDTH     = 32,
    parameter int THREAD_WIDTH = 256,
    parameter int STACK_DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // warp launch
    input  logic                    launch_valid,
    output logic                    launch_ready,
    input  logic [PC_WIDTH-1:0]     launch_pc,
    input  logic [THREAD_WIDTH-1:0] launch_mask,
    // block dispatch to fetch
    output logic                    disp_valid,
    input  logic                    disp_ready,
    output logic [PC_WIDTH-1:0]     disp_pc,
    output logic [THREAD_WIDTH-1:0] disp_mask,
    // block completion report
    input  logic                    done_valid,
    output logic                    done_ready,
    input  logic [1:0]              done_kind,
    input  logic [PC_WIDTH-1:0]     done_next_pc,
    input  logic [THREAD_WIDTH-1:0] done_taken_mask,
    input  logic [PC_WIDTH-1:0]     done_taken_pc,
    input  logic [PC_WIDTH-1:0]     done_nt_pc,
    input  logic [PC_WIDTH-1:0]     done_reconv_pc,
    // status
    output logic                    warp_done,
    output logic                    err_overflow,
    output logic                    err_kind,
    // stack command port
    output logic                    stk_push,
    output logic                    stk_pop,
    output logic                    stk_read_top,
    output logic                    stk_modify_top,
    output logic [PC_WIDTH-1:0]     stk_push_next_pc,
    output logic [PC_WIDTH-1:0]     stk_push_rpc,
    output logic [THREAD_WIDTH-1:0] stk_push_mask,
    input  logic [PC_WIDTH-1:0]     stk_top_next_pc,
    input  logic [PC_WIDTH-1:0]     stk_top_rpc,
    input  logic [THREAD_WIDTH-1:0] stk_top_mask,
    input  logic                    stk_out_valid
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    // A divergent split needs two free entries, so refuse it above this occupancy.
    localparam logic [DW-1:0] DEPTH_LIMIT = DW'(STACK_DEPTH - 2);
    localparam logic [PC_WIDTH-1:0] RPC_NONE = '1;

    localparam logic [1:0] KIND_FT   = 2'd0;
    localparam logic [1:0] KIND_BR   = 2'd1;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT_DONE,
        S_PUSH_RECONV,
        S_PUSH_NT,
        S_POP,
        S_LOAD,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [PC_WIDTH-1:0]     cur_pc_q, cur_pc_d;
    logic [THREAD_WIDTH-1:0] cur_mask_q, cur_mask_d;
    logic [PC_WIDTH-1:0]     cur_rpc_q, cur_rpc_d;
    logic [THREAD_WIDTH-1:0] exited_q, exited_d;
    logic [DW-1:0]           depth_q, depth_d;
    // Pending split: not-taken side and the context that was live before the split.
    logic [PC_WIDTH-1:0]     nt_pc_q, nt_pc_d;
    logic [THREAD_WIDTH-1:0] nt_mask_q, nt_mask_d;
    logic [PC_WIDTH-1:0]     reconv_pc_q, reconv_pc_d;
    logic [PC_WIDTH-1:0]     old_rpc_q, old_rpc_d;
    logic [THREAD_WIDTH-1:0] old_mask_q, old_mask_d;
    logic                    err_overflow_q, err_overflow_d;
    logic                    err_kind_q, err_kind_d;

    logic [THREAD_WIDTH-1:0] taken_live;
    logic [THREAD_WIDTH-1:0] ntaken_live;
    logic [THREAD_WIDTH-1:0] top_live;
    logic [PC_WIDTH-1:0]     nxt_pc;
    logic                    is_uniform;

    // Per-thread split of the branch predicate and survivors of a popped entry.
    always_comb begin
        taken_live  = done_taken_mask & cur_mask_q;
        ntaken_live = cur_mask_q & ~done_taken_mask;
        top_live    = stk_top_mask & ~exited_q;
    end

    // Next-state, datapath updates and all handshake/stack outputs.
    always_comb begin
        state_d        = state_q;
        cur_pc_d       = cur_pc_q;
        cur_mask_d     = cur_mask_q;
        cur_rpc_d      = cur_rpc_q;
        exited_d       = exited_q;
        depth_d        = depth_q;
        nt_pc_d        = nt_pc_q;
        nt_mask_d      = nt_mask_q;
        reconv_pc_d    = reconv_pc_q;
        old_rpc_d      = old_rpc_q;
        old_mask_d     = old_mask_q;
        err_overflow_d = err_overflow_q;
        err_kind_d     = err_kind_q;

        launch_ready     = 1'b0;
        disp_valid       = 1'b0;
        disp_pc          = '0;
        disp_mask        = '0;
        done_ready       = 1'b0;
        warp_done        = 1'b0;
        stk_push         = 1'b0;
        stk_pop          = 1'b0;
        stk_read_top     = 1'b0;
        stk_push_next_pc = '0;
        stk_push_rpc     = '0;
        stk_push_mask    = '0;
        nxt_pc           = done_next_pc;
        is_uniform       = 1'b1;

        case (state_q)
            S_IDLE: begin
                launch_ready = 1'b1;
                if (launch_valid) begin
                    cur_pc_d       = launch_pc;
                    cur_mask_d     = launch_mask;
                    cur_rpc_d      = RPC_NONE;
                    exited_d       = '0;
                    depth_d        = '0;
                    err_overflow_d = 1'b0;
                    err_kind_d     = 1'b0;
                    state_d        = S_DISPATCH;
                end
            end

            S_DISPATCH: begin
                disp_valid = 1'b1;
                disp_pc    = cur_pc_q;
                disp_mask  = cur_mask_q;
                if (disp_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                done_ready = 1'b1;
                if (done_valid) begin
                    if (done_kind == KIND_RSVD) begin
                        err_kind_d = 1'b1;
                    end
                    if (done_kind == KIND_FT || done_kind == KIND_BR) begin
                        if (done_kind == KIND_BR) begin
                            if (taken_live == '0) begin
                                nxt_pc = done_nt_pc;
                            end else if (ntaken_live == '0) begin
                                nxt_pc = done_taken_pc;
                            end else begin
                                is_uniform = 1'b0;
                            end
                        end
                        if (!is_uniform) begin
                            if (depth_q > DEPTH_LIMIT) begin
                                err_overflow_d = 1'b1;
                                state_d        = S_ERROR;
                            end else begin
                                nt_pc_d     = done_nt_pc;
                                nt_mask_d   = ntaken_live;
                                reconv_pc_d = done_reconv_pc;
                                old_rpc_d   = cur_rpc_q;
                                old_mask_d  = cur_mask_q;
                                cur_pc_d    = done_taken_pc;
                                cur_mask_d  = taken_live;
                                cur_rpc_d   = done_reconv_pc;
                                state_d     = S_PUSH_RECONV;
                            end
                        end else if (nxt_pc == cur_rpc_q && depth_q != '0) begin
                            // Reached the join point: the stacked context takes over.
                            state_d = S_POP;
                        end else begin
                            cur_pc_d = nxt_pc;
                            state_d  = S_DISPATCH;
                        end
                    end else begin
                        // Exit (and the reserved kind, handled identically).
                        exited_d = exited_q | cur_mask_q;
                        if (depth_q == '0) begin
                            warp_done = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_POP;
                        end
                    end
                end
            end

            S_PUSH_RECONV: begin
                stk_push         = 1'b1;
                stk_push_next_pc = reconv_pc_q;
                stk_push_rpc     = old_rpc_q;
                stk_push_mask    = old_mask_q;
                depth_d          = depth_q + DW'(1);
                state_d          = S_PUSH_NT;
            end

            S_PUSH_NT: begin
                stk_push         = 1'b1;
                stk_push_next_pc = nt_pc_q;
                stk_push_rpc     = reconv_pc_q;
                stk_push_mask    = nt_mask_q;
                depth_d          = depth_q + DW'(1);
                state_d          = S_DISPATCH;
            end

            S_POP: begin
                // The stack reads the top with the pre-pop pointer, so both go together.
                stk_read_top = 1'b1;
                stk_pop      = 1'b1;
                depth_d      = depth_q - DW'(1);
                state_d      = S_LOAD;
            end

            S_LOAD: begin
                if (stk_out_valid) begin
                    if (top_live != '0) begin
                        cur_pc_d   = stk_top_next_pc;
                        cur_mask_d = top_live;
                        cur_rpc_d  = stk_top_rpc;
                        state_d    = S_DISPATCH;
                    end else if (depth_q != '0) begin
                        // Every thread of this entry has exited; skip to the next one.
                        state_d = S_POP;
                    end else begin
                        warp_done = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stk_modify_top = 1'b0;
    assign err_overflow   = err_overflow_q;
    assign err_kind       = err_kind_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Warp context, split bookkeeping and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_pc_q       <= '0;
            cur_mask_q     <= '0;
            cur_rpc_q      <= RPC_NONE;
            exited_q       <= '0;
            depth_q        <= '0;
            nt_pc_q        <= '0;
            nt_mask_q      <= '0;
            reconv_pc_q    <= '0;
            old_rpc_q      <= '0;
            old_mask_q     <= '0;
            err_overflow_q <= 1'b0;
            err_kind_q     <= 1'b0;
        end else begin
            cur_pc_q       <= cur_pc_d;
            cur_mask_q     <= cur_mask_d;
            cur_rpc_q      <= cur_rpc_d;
            exited_q       <= exited_d;
            depth_q        <= depth_d;
            nt_pc_q        <= nt_pc_d;
            nt_mask_q      <= nt_mask_d;
            reconv_pc_q    <= reconv_pc_d;
            old_rpc_q      <= old_rpc_d;
            old_mask_q     <= old_mask_d;
            err_overflow_q <= err_overflow_d;
            err_kind_q     <= err_kind_d;
        end
    end

endmodule

// File: tb/tb_simt_divergence_ctrl.sv
// Purpose: scoreboard bench for simt_divergence_ctrl with a behavioural simt_stack attached.
// Latency: dispatch latencies are checked against the cycle of the last done handshake.
// Backpressure: disp_ready is held low once to check that dispatch outputs stay stable.
module tb_simt_divergence_ctrl;

    localparam int PW = 32;
    localparam int TW = 8;
    localparam int SD = 4;
    localparam logic [PW-1:0] NONE = 32'hFFFF_FFFF;

    localparam int K_DISP = 0;
    localparam int K_PUSH = 1;
    localparam int K_POP  = 2;
    localparam int K_DONE = 3;

    logic clk, rst;
    logic launch_valid, launch_ready;
    logic [PW-1:0] launch_pc;
    logic [TW-1:0] launch_mask;
    logic disp_valid, disp_ready;
    logic [PW-1:0] disp_pc;
    logic [TW-1:0] disp_mask;
    logic done_valid, done_ready;
    logic [1:0] done_kind;
    logic [PW-1:0] done_next_pc, done_taken_pc, done_nt_pc, done_reconv_pc;
    logic [TW-1:0] done_taken_mask;
    logic warp_done, err_overflow, err_kind;
    logic stk_push, stk_pop, stk_read_top, stk_modify_top;
    logic [PW-1:0] stk_push_next_pc, stk_push_rpc;
    logic [TW-1:0] stk_push_mask;
    logic [PW-1:0] stk_top_next_pc, stk_top_rpc;
    logic [TW-1:0] stk_top_mask;
    logic stk_out_valid;

    typedef struct {
        int            kind;
        logic [PW-1:0] pc;
        logic [PW-1:0] rpc;
        logic [TW-1:0] mask;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = 0;

    simt_divergence_ctrl #(
        .PC_WIDTH(PW), .THREAD_WIDTH(TW), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk), .rst(rst),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_pc(launch_pc), .launch_mask(launch_mask),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_mask(disp_mask),
        .done_valid(done_valid), .done_ready(done_ready), .done_kind(done_kind),
        .done_next_pc(done_next_pc), .done_taken_mask(done_taken_mask),
        .done_taken_pc(done_taken_pc), .done_nt_pc(done_nt_pc), .done_reconv_pc(done_reconv_pc),
        .warp_done(warp_done), .err_overflow(err_overflow), .err_kind(err_kind),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_read_top(stk_read_top),
        .stk_modify_top(stk_modify_top),
        .stk_push_next_pc(stk_push_next_pc), .stk_push_rpc(stk_push_rpc), .stk_push_mask(stk_push_mask),
        .stk_top_next_pc(stk_top_next_pc), .stk_top_rpc(stk_top_rpc), .stk_top_mask(stk_top_mask),
        .stk_out_valid(stk_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural simt_stack: registered top read using the pre-pop pointer.
    logic [PW-1:0] sm_pc [SD];
    logic [PW-1:0] sm_rpc [SD];
    logic [TW-1:0] sm_mask [SD];
    logic [2:0]    sp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp              <= 3'd0;
            stk_out_valid   <= 1'b0;
            stk_top_next_pc <= '0;
            stk_top_rpc     <= '0;
            stk_top_mask    <= '0;
        end else begin
            stk_out_valid <= stk_read_top;
            if (stk_read_top && sp != 3'd0) begin
                stk_top_next_pc <= sm_pc[2'(sp - 3'd1)];
                stk_top_rpc     <= sm_rpc[2'(sp - 3'd1)];
                stk_top_mask    <= sm_mask[2'(sp - 3'd1)];
            end
            if (stk_push && sp < 3'(SD)) begin
                sm_pc[sp[1:0]]   <= stk_push_next_pc;
                sm_rpc[sp[1:0]]  <= stk_push_rpc;
                sm_mask[sp[1:0]] <= stk_push_mask;
                sp <= sp + 3'd1;
            end else if (stk_pop && sp != 3'd0) begin
                sp <= sp - 3'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic exp_disp(input logic [PW-1:0] pc, input logic [TW-1:0] m, input int lat);
        exp_t e;
        e.kind = K_DISP; e.pc = pc; e.rpc = '0; e.mask = m; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic exp_push(input logic [PW-1:0] pc, input logic [PW-1:0] rpc, input logic [TW-1:0] m);
        exp_t e;
        e.kind = K_PUSH; e.pc = pc; e.rpc = rpc; e.mask = m; e.lat = 0;
        exp_q.push_back(e);
    endtask

    task automatic exp_ev(input int kind);
        exp_t e;
        e.kind = kind; e.pc = '0; e.rpc = '0; e.mask = '0; e.lat = 0;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind, input logic [PW-1:0] pc, input logic [PW-1:0] rpc,
                       input logic [TW-1:0] m);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d pc %0h mask %0h want none", kind, pc, m);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (kind == e.kind && kind == K_DISP) begin
                chk("disp_pc", 64'(pc), 64'(e.pc));
                chk("disp_mask", 64'(m), 64'(e.mask));
                if (e.lat > 0) chk("disp_latency", 64'(cyc - last_done), 64'(e.lat));
            end
            if (kind == e.kind && kind == K_PUSH) begin
                chk("push_next_pc", 64'(pc), 64'(e.pc));
                chk("push_rpc", 64'(rpc), 64'(e.rpc));
                chk("push_mask", 64'(m), 64'(e.mask));
            end
        end
    endtask

    // Monitor: every observed DUT event is matched against the scoreboard queue.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done_valid && done_ready) last_done = cyc;
                if (stk_push && stk_pop) chk("push_pop_together", 64'(1), 64'(0));
                if (warp_done) begin
                    chk("done_no_stack_cmd", 64'(stk_push | stk_pop | stk_read_top), 64'(0));
                    see(K_DONE, '0, '0, '0);
                end
                if (stk_pop) begin
                    chk("pop_not_empty", 64'(sp != 3'd0), 64'(1));
                    see(K_POP, '0, '0, '0);
                end
                if (stk_push) begin
                    chk("push_not_full", 64'(sp < 3'(SD)), 64'(1));
                    see(K_PUSH, stk_push_next_pc, stk_push_rpc, stk_push_mask);
                end
                if (disp_valid && disp_ready) see(K_DISP, disp_pc, '0, disp_mask);
            end
        end
    endtask

    task automatic launch(input logic [PW-1:0] pc, input logic [TW-1:0] m);
        bit ok;
        ok = 1'b0;
        launch_pc = pc; launch_mask = m; launch_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (launch_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("launch_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 launch_valid = 1'b0;
    endtask

    task automatic do_done(input logic [1:0] k, input logic [PW-1:0] npc, input logic [TW-1:0] tm,
                           input logic [PW-1:0] tpc, input logic [PW-1:0] ntpc, input logic [PW-1:0] rpc);
        bit ok;
        ok = 1'b0;
        done_kind = k; done_next_pc = npc; done_taken_mask = tm;
        done_taken_pc = tpc; done_nt_pc = ntpc; done_reconv_pc = rpc;
        done_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("done_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 done_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // Launch plus the 0x0F / 0x200 / 0x300 / 0x400 split used by several scenarios.
    task automatic launch_and_split();
        exp_disp(32'h100, 8'hFF, 0);
        launch(32'h100, 8'hFF);
        exp_push(32'h400, NONE, 8'hFF);
        exp_push(32'h300, 32'h400, 8'hF0);
        exp_disp(32'h200, 8'h0F, 3);
        do_done(2'd1, 32'h0, 8'h0F, 32'h200, 32'h300, 32'h400);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; launch_valid = 1'b0; launch_pc = '0; launch_mask = '0;
        disp_ready = 1'b1; done_valid = 1'b0; done_kind = '0; done_next_pc = '0;
        done_taken_mask = '0; done_taken_pc = '0; done_nt_pc = '0; done_reconv_pc = '0;
        fork
            monitor();
        join_none

        // Reset state
        #3;
        chk("rst_launch_ready", 64'(launch_ready), 64'(1));
        chk("rst_disp_valid", 64'(disp_valid), 64'(0));
        chk("rst_done_ready", 64'(done_ready), 64'(0));
        chk("rst_warp_done", 64'(warp_done), 64'(0));
        chk("rst_stk_cmds", 64'({stk_push, stk_pop, stk_read_top, stk_modify_top}), 64'(0));
        chk("rst_errs", 64'({err_overflow, err_kind}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Uniform fall-through with initial dispatch backpressure
        disp_ready = 1'b0;
        exp_disp(32'h100, 8'hFF, 0);
        launch(32'h100, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_disp_valid", 64'(disp_valid), 64'(1));
            chk("bp_disp_pc", 64'(disp_pc), 64'(32'h100));
            chk("bp_disp_mask", 64'(disp_mask), 64'(8'hFF));
        end
        @(posedge clk);
        #1 disp_ready = 1'b1;
        exp_disp(32'h140, 8'hFF, 1);
        do_done(2'd0, 32'h140, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("uniform_drained");

        // Divergent branch and two-step reconvergence
        launch_and_split();
        exp_ev(K_POP);
        exp_disp(32'h300, 8'hF0, 3);
        do_done(2'd0, 32'h400, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_POP);
        exp_disp(32'h400, 8'hFF, 3);
        do_done(2'd0, 32'h400, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("diverge_drained");
        chk("diverge_stack_empty", 64'(sp), 64'(0));
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("diverge_exit_drained");

        // Uniform-predicate branches: no pushes
        exp_disp(32'h100, 8'hFF, 0);
        launch(32'h100, 8'hFF);
        exp_disp(32'h300, 8'hFF, 1);
        do_done(2'd1, 32'h0, 8'h00, 32'h200, 32'h300, 32'h400);
        exp_disp(32'h200, 8'hFF, 1);
        do_done(2'd1, 32'h0, 8'hFF, 32'h200, 32'h300, 32'h400);
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("upred_drained");

        // Taken side exits inside the divergence
        launch_and_split();
        exp_ev(K_POP);
        exp_disp(32'h300, 8'hF0, 3);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_POP);
        exp_disp(32'h400, 8'hF0, 3);
        do_done(2'd0, 32'h400, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("exitdiv_drained");

        // Nested split; a fully exited entry is skipped; reserved kind flags err_kind
        launch_and_split();
        exp_push(32'h230, 32'h400, 8'h0F);
        exp_push(32'h220, 32'h230, 8'h0C);
        exp_disp(32'h210, 8'h03, 3);
        do_done(2'd1, 32'h0, 8'h03, 32'h210, 32'h220, 32'h230);
        exp_ev(K_POP);
        exp_disp(32'h220, 8'h0C, 3);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_POP);
        exp_ev(K_POP);
        exp_disp(32'h300, 8'hF0, 5);
        do_done(2'd3, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_POP);
        exp_disp(32'h400, 8'hF0, 3);
        do_done(2'd0, 32'h400, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("nested_drained");
        chk("err_kind_sticky", 64'(err_kind), 64'(1));

        // Overflow on the third nested split
        launch_and_split();
        chk("err_kind_cleared", 64'(err_kind), 64'(0));
        exp_push(32'h230, 32'h400, 8'h0F);
        exp_push(32'h220, 32'h230, 8'h0C);
        exp_disp(32'h210, 8'h03, 3);
        do_done(2'd1, 32'h0, 8'h03, 32'h210, 32'h220, 32'h230);
        do_done(2'd1, 32'h0, 8'h01, 32'h500, 32'h600, 32'h700);
        drain("overflow_drained");
        repeat (5) @(negedge clk);
        chk("ovf_err_overflow", 64'(err_overflow), 64'(1));
        chk("ovf_handshakes_low", 64'({launch_ready, disp_valid, done_ready}), 64'(0));
        chk("ovf_stack_depth", 64'(sp), 64'(4));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("ovf_rst_launch_ready", 64'(launch_ready), 64'(1));
        chk("ovf_rst_err_overflow", 64'(err_overflow), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset while waiting in LOAD
        launch_and_split();
        exp_ev(K_POP);
        do_done(2'd0, 32'h400, 8'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("load_pop_seen", 64'(stk_pop), 64'(1));
        @(posedge clk);
        #2;
        chk("load_stk_out_valid", 64'(stk_out_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("arst_launch_ready", 64'(launch_ready), 64'(1));
        chk("arst_outputs_low", 64'({disp_valid, done_ready, warp_done, stk_push, stk_pop, stk_read_top}), 64'(0));
        drain("arst_drained");
        @(posedge clk);
        #1 rst = 1'b0;
        exp_disp(32'h100, 8'hFF, 0);
        launch(32'h100, 8'hFF);
        exp_disp(32'h140, 8'hFF, 1);
        do_done(2'd0, 32'h140, 8'h0, 32'h0, 32'h0, 32'h0);
        exp_ev(K_DONE);
        do_done(2'd2, 32'h0, 8'h0, 32'h0, 32'h0, 32'h0);
        drain("relaunch_drained");
        chk("relaunch_stack_empty", 64'(sp), 64'(0));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
